alu_muldiv_ctrl: RTL and testbench
==================================

// Module: alu_muldiv_ctrl
// PURPOSE
//   Multicycle sequencer for the MUL (funct 4'b0010) and DIV (funct 4'b0011) R-type ops
//   of the 16-bit MIPS core. Runs an iterative shift-add multiply / restoring divide
//   over WIDTH cycles. Holds the datapath via stall while busy. Returns a 2*WIDTH
//   product or a quotient/remainder pair to the register-file write path.
// PARAMETERS
//   WIDTH     16   operand width; product is 2*WIDTH, quotient/remainder each WIDTH
//   CNT_W     5    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        asynchronous, active-low reset
//   start      in   1        request strobe, sampled only in IDLE or DONE
//   funct      in   4        R-type funct; 4'b0010 = MUL, 4'b0011 = DIV, others ignored
//   a          in   WIDTH    multiplicand / dividend
//   b          in   WIDTH    multiplier / divisor
//   busy       out  1        high while an op is iterating
//   stall      out  1        pipeline hold; equals busy
//   done       out  1        one-cycle pulse; results valid that cycle and held after
//   result_hi  out  WIDTH    MUL: product[2W-1:W]; DIV: remainder
//   result_lo  out  WIDTH    MUL: product[W-1:0];  DIV: quotient
//   dz         out  1        divide-by-zero flag, valid with done, held with results
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; busy, stall, done, dz, result_hi, result_lo, counter = 0.
//   FSM states: IDLE, MUL, DIV, DONE.
//   - IDLE/DONE with start=1, funct=MUL: latch a, b. Clear accumulator. Counter=WIDTH. Go to MUL.
//   - IDLE/DONE with start=1, funct=DIV, b!=0: latch operands. Clear partial remainder.
//     Counter=WIDTH. Go to DIV.
//   - IDLE/DONE with start=1, funct=DIV, b==0: go to DONE next cycle.
//     Result: result_lo=all ones, result_hi=a, dz=1. No iteration.
//   - IDLE/DONE with start=1, any other funct: ignored; stay/return to IDLE.
//   - MUL: each cycle, if multiplier LSB=1, add multiplicand to upper half.
//     Then shift {carry,acc} right 1. Decrement counter. Counter reaches 0 -> DONE.
//   - DIV: each cycle, shift {rem,quot} left 1 and trial-subtract b from rem.
//     If no borrow: keep difference, set quot LSB. Otherwise restore.
//     Counter reaches 0 -> DONE.
//   - DONE: done=1 for exactly this cycle. Results registered and stable until the
//     next accepted start. Without a new start, the next state is IDLE.
//   Timing: start accepted at edge N -> busy=1 for cycles N+1..N+WIDTH.
//   done=1 and busy=0 at cycle N+WIDTH+1. Latency is WIDTH+1 cycles (17 at default).
//   Divide-by-zero latency is 1 cycle.
//   Back-to-back: start during the DONE cycle is accepted. Next busy begins the following cycle.
//   start while busy=1: ignored; operands not relatched; no error raised.
//   dz cleared on every accepted start. Arithmetic unsigned, modulo widths above.
//   No overflow flag.
//   reset asserted mid-operation: abort immediately to reset values; no done pulse.
// CONFIGURATION
//   MULDIV_SIGNED_EN defined: a and b are two's complement.
//   - Magnitudes are taken at accept.
//   - In DONE: product negated if signs differ; quotient negated if signs differ;
//     remainder takes the sign of the dividend.
//   - Latency unchanged; sign fix-up is combinational into the DONE register load.
//   - Divide-by-zero result: quotient all ones, remainder = a.
//   - 16'h8000 / 16'hFFFF: quotient 16'h8000, remainder 0, dz=0.
//   MULDIV_SIGNED_EN undefined: all operands and results unsigned; no sign logic synthesised.
// TESTING
//   1. MUL a=7, b=9, start 1 cycle -> busy 16 cycles; done at +17;
//      hi=16'h0000, lo=16'h003F, dz=0.
//   2. MUL a=16'hFFFF, b=16'hFFFF (unsigned) -> hi=16'hFFFE, lo=16'h0001.
//   3. DIV a=100, b=7 -> lo (quot)=14, hi (rem)=2 at +17.
//      Back-to-back DIV 9/3 started in the DONE cycle -> quot=3, rem=0.
//   4. DIV a=5, b=0 -> done at +1, busy never high, dz=1, lo=16'hFFFF, hi=16'h0005.
//   5. Start MUL 3*4, re-pulse start with funct=DIV, a=1, b=1 at +5
//      -> ignored; final lo=12. Reset low at +8 -> all outputs 0 immediately, no done.
//   6. MULDIV_SIGNED_EN: MUL -6*7 -> {hi,lo}=32'hFFFF_FFD6.
//      DIV -7/2 -> quot=16'hFFFD, rem=16'hFFFF.

Source files
------------

// File: rtl/alu_muldiv_ctrl_if.sv
// Request/response bundle between the MIPS execute stage and the MUL/DIV sequencer.
// Latency: none, wires only; the sequencer owns all timing.
// Backpressure: the sequencer drives stall/busy back toward the requester.
interface alu_muldiv_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [3:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             dz;

  modport master (
    output start, funct, a, b,
    input  busy, stall, done, result_hi, result_lo, dz
  );

  modport slave (
    input  start, funct, a, b,
    output busy, stall, done, result_hi, result_lo, dz
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// Iterative MUL (shift-add) / DIV (restoring) sequencer; optional signed mode via MULDIV_SIGNED_EN.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero finishes in 1 cycle.
// Backpressure: stall=busy holds the pipeline; start is ignored while iterating.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  alu_muldiv_ctrl_if.slave bus
);
  localparam logic [3:0] FUNCT_MUL = 4'b0010;
  localparam logic [3:0] FUNCT_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  // mcand holds the multiplicand (MUL) or divisor (DIV).
  // {hi,lo} is the product accumulator (MUL) or {remainder,quotient} (DIV).
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_hi, result_lo;
  logic             dz;

  logic can_start, is_mul, is_div, div_zero, accept, last;
  assign can_start = (state == IDLE) || (state == DONE);
  assign is_mul    = bus.start && (bus.funct == FUNCT_MUL);
  assign is_div    = bus.start && (bus.funct == FUNCT_DIV);
  assign div_zero  = is_div && (bus.b == '0);
  assign accept    = can_start && (is_mul || is_div);
  assign last      = (cnt == CNT_W'(1));

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, then shift {carry,hi,lo} right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  assign mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};

  // One restoring-divide step: shift the next dividend bit into the
  // remainder and keep the trial difference only when it did not borrow.
  logic [WIDTH:0]   div_shift, div_trial;
  logic             no_borrow;
  logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;
  assign div_shift  = {hi, lo[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, mcand};
  assign no_borrow  = ~div_trial[WIDTH];
  assign div_hi_nxt = no_borrow ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_nxt = {lo[WIDTH-2:0], no_borrow};

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

`ifdef MULDIV_SIGNED_EN
  logic sign_a, sign_b;
  assign a_mag    = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag    = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign prod_fix = (sign_a ^ sign_b) ? -{mul_hi_nxt, mul_lo_nxt} : {mul_hi_nxt, mul_lo_nxt};
  assign quot_fix = (sign_a ^ sign_b) ? -div_lo_nxt : div_lo_nxt;
  assign rem_fix  = sign_a ? -div_hi_nxt : div_hi_nxt;

  // Remember operand signs at accept for the fix-up folded into the DONE load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (accept) begin
      sign_a <= bus.a[WIDTH-1];
      sign_b <= bus.b[WIDTH-1];
    end
  end
`else
  assign a_mag    = bus.a;
  assign b_mag    = bus.b;
  assign prod_fix = {mul_hi_nxt, mul_lo_nxt};
  assign quot_fix = div_lo_nxt;
  assign rem_fix  = div_hi_nxt;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept only from IDLE/DONE, iterate until the counter expires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (is_mul)        state_nxt = MUL;
        else if (div_zero) state_nxt = DONE;
        else if (is_div)   state_nxt = DIV;
      end
      MUL:     if (last) state_nxt = DONE;
      DIV:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      result_hi <= '0;
      result_lo <= '0;
      dz        <= 1'b0;
    end else if (accept) begin
      cnt <= CNT_W'(WIDTH);
      hi  <= '0;
      dz  <= 1'b0;
      if (is_mul) begin
        mcand <= a_mag;
        lo    <= b_mag;
      end else if (div_zero) begin
        // No iteration: the answer is known at accept.
        result_lo <= '1;
        result_hi <= bus.a;
        dz        <= 1'b1;
      end else begin
        mcand <= b_mag;
        lo    <= a_mag;
      end
    end else if (state == MUL) begin
      hi  <= mul_hi_nxt;
      lo  <= mul_lo_nxt;
      cnt <= cnt - CNT_W'(1);
      if (last) {result_hi, result_lo} <= prod_fix;
    end else if (state == DIV) begin
      hi  <= div_hi_nxt;
      lo  <= div_lo_nxt;
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        result_hi <= rem_fix;
        result_lo <= quot_fix;
      end
    end
  end

  assign bus.busy      = (state == MUL) || (state == DIV);
  assign bus.stall     = bus.busy;
  assign bus.done      = (state == DONE);
  assign bus.result_hi = result_hi;
  assign bus.result_lo = result_lo;
  assign bus.dz        = dz;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboard bench for alu_muldiv_ctrl: directed cases plus randomized ops vs. an arithmetic model.
// Latency: expects WIDTH+1 cycles per op, 1 cycle for divide-by-zero.
// Backpressure: new ops are issued only when idle or in the DONE cycle.
module tb_alu_muldiv_ctrl;
  localparam int W = 16;
  localparam logic [3:0] F_MUL = 4'b0010;
  localparam logic [3:0] F_DIV = 4'b0011;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           busy;
    int           t0;
    int           id;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  alu_muldiv_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s op%0d actual=%0h required=%0h", nm, id, act, req);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [2*W-1:0] p;
    int sa, sb_v, q, r;
    e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = W + 1; e.busy = W; e.t0 = 0; e.id = 0;
    sa = int'($signed(av));
    sb_v = int'($signed(bv));
    if (f == F_DIV && bv == '0) begin
      e.hi = av; e.lo = '1; e.dz = 1'b1; e.lat = 1; e.busy = 0;
    end else if (f == F_MUL) begin
`ifdef MULDIV_SIGNED_EN
      p = 32'(sa * sb_v);
`else
      p = {16'b0, av} * {16'b0, bv};
`endif
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else begin
`ifdef MULDIV_SIGNED_EN
      q = sa / sb_v;
      r = sa % sb_v;
      e.lo = W'(q);
      e.hi = W'(r);
`else
      q = 0; r = 0;
      e.lo = av / bv;
      e.hi = av % bv;
`endif
    end
    return e;
  endfunction

  // Drive one start pulse from a negedge; optionally record the expected response.
  task automatic issue(input logic [3:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit push, input int id);
    exp_t e;
    bus.start = 1'b1; bus.funct = f; bus.a = av; bus.b = bv;
    if (push) begin
      e = model(f, av, bv);
      e.t0 = cyc;
      e.id = id;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int id);
    int n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout op%0d actual=no_done required=done", id);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      chk("stall_eq_busy", -1, 64'(bus.stall), 64'(bus.busy));
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc%0d actual=done required=no_done", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("result_hi", mon_e.id, 64'(bus.result_hi), 64'(mon_e.hi));
          chk("result_lo", mon_e.id, 64'(bus.result_lo), 64'(mon_e.lo));
          chk("dz",        mon_e.id, 64'(bus.dz),        64'(mon_e.dz));
          chk("latency",   mon_e.id, 64'(cyc - mon_e.t0), 64'(mon_e.lat));
          chk("busy_cycles", mon_e.id, 64'(busy_cnt),    64'(mon_e.busy));
        end
        busy_cnt = 0;
      end
    end
  end

  logic [3:0]   rf;
  logic [W-1:0] ra, rb;
  int           kind;
  bit           b2b;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
    #1;
    chk("reset_outputs", 0, {28'b0, bus.busy, bus.stall, bus.done, bus.dz, bus.result_hi, bus.result_lo}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    issue(F_MUL, 16'd7, 16'd9, 1, 1);
    wait_done(1);
    chk("mul7x9_lo", 1, 64'(bus.result_lo), 64'h003F);
    chk("mul7x9_hi", 1, 64'(bus.result_hi), 64'h0000);
    @(negedge clk);

    issue(F_MUL, 16'hFFFF, 16'hFFFF, 1, 2);
    wait_done(2);
`ifndef MULDIV_SIGNED_EN
    chk("mulffff_hi", 2, 64'(bus.result_hi), 64'hFFFE);
    chk("mulffff_lo", 2, 64'(bus.result_lo), 64'h0001);
`endif
    @(negedge clk);

    issue(F_DIV, 16'd100, 16'd7, 1, 3);
    wait_done(3);
    chk("div100_7_q", 3, 64'(bus.result_lo), 64'd14);
    chk("div100_7_r", 3, 64'(bus.result_hi), 64'd2);
    issue(F_DIV, 16'd9, 16'd3, 1, 4);
    wait_done(4);
    chk("div9_3_q", 4, 64'(bus.result_lo), 64'd3);
    @(negedge clk);

    issue(F_DIV, 16'd5, 16'd0, 1, 5);
    wait_done(5);
    chk("dz_flag", 5, 64'(bus.dz), 64'd1);
    chk("dz_lo",   5, 64'(bus.result_lo), 64'hFFFF);
    chk("dz_hi",   5, 64'(bus.result_hi), 64'h0005);
    @(negedge clk);

    issue(F_MUL, 16'd3, 16'd4, 1, 6);
    repeat (3) @(negedge clk);
    bus.start = 1'b1; bus.funct = F_DIV; bus.a = 16'd1; bus.b = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(6);
    chk("ignored_start_lo", 6, 64'(bus.result_lo), 64'd12);
    @(negedge clk);

    issue(F_MUL, 16'd3, 16'd4, 0, 7);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midop_reset", 7, {28'b0, bus.busy, bus.stall, bus.done, bus.dz, bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(negedge clk);

    issue(4'b0101, 16'd8, 16'd2, 0, 8);
    repeat (2) @(negedge clk);
    chk("other_funct_idle", 8, {62'b0, bus.busy, bus.done}, 64'd0);

`ifdef MULDIV_SIGNED_EN
    issue(F_MUL, 16'hFFFA, 16'd7, 1, 9);
    wait_done(9);
    chk("smul_-6x7", 9, {32'b0, bus.result_hi, bus.result_lo}, 64'hFFFF_FFD6);
    @(negedge clk);
    issue(F_DIV, 16'hFFF9, 16'd2, 1, 10);
    wait_done(10);
    chk("sdiv_-7_2_q", 10, 64'(bus.result_lo), 64'hFFFD);
    chk("sdiv_-7_2_r", 10, 64'(bus.result_hi), 64'hFFFF);
    @(negedge clk);
    issue(F_DIV, 16'h8000, 16'hFFFF, 1, 11);
    wait_done(11);
    chk("sdiv_min_q", 11, {47'b0, bus.dz, bus.result_lo}, 64'h8000);
    chk("sdiv_min_r", 11, 64'(bus.result_hi), 64'h0000);
    @(negedge clk);
`endif

    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      ra = W'($urandom);
      rb = W'($urandom);
      if (kind == 8) rb = '0;
      if (kind < 4)      rf = F_MUL;
      else if (kind < 9) rf = F_DIV;
      else               rf = 4'($urandom_range(4, 15));
      if (!b2b) @(negedge clk);
      if (kind == 9) begin
        issue(rf, ra, rb, 0, 100 + i);
        repeat (3) @(negedge clk);
        b2b = 1'b0;
      end else begin
        issue(rf, ra, rb, 1, 100 + i);
        wait_done(100 + i);
        b2b = bit'($urandom_range(0, 1));
      end
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 0, 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
